// File: rtl/mem_fill_seq.sv
// Memory fill sequencer: writes DEPTH words at ascending addresses with an
// identity, constant, ramp or reverse-identity data pattern.
module mem_fill_seq #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill_value,
  input  logic [DATA_W-1:0] stride,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  typedef enum logic [1:0] {M_IDENT, M_CONST, M_RAMP, M_REV} mode_e;

  localparam logic [ADDR_W-1:0] LAST_K  = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] REV_TOP = DATA_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;
  mode_e             mode_q, mode_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] stride_q, stride_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wren_q, wren_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic accept;
  logic last;

  assign accept = (state_q != S_RUN) && start && !abort;
  assign last   = (k_q == LAST_K);

  // NOTE: every flop is updated with non-blocking assignments so that all
  // registers sample the pre-edge values of each other, independent of order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      mode_q   <= M_IDENT;
      fill_q   <= '0;
      stride_q <= '0;
      data_q   <= '0;
      wren_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      mode_q   <= mode_d;
      fill_q   <= fill_d;
      stride_q <= stride_d;
      data_q   <= data_d;
      wren_q   <= wren_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // NOTE: each combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN: begin
        if (abort)     state_d = S_IDLE;
        else if (last) state_d = S_DONE;
      end
      default: begin
        if (abort)      state_d = S_IDLE;
        else if (start) state_d = S_RUN;
      end
    endcase
  end

  // The ramp uses data_q as its accumulator: it always holds pattern(k-1).
  always_comb begin
    mode_d   = mode_q;
    fill_d   = fill_q;
    stride_d = stride_q;
    k_d      = k_q;
    data_d   = data_q;
    wren_d   = 1'b0;
    busy_d   = (state_d == S_RUN);
    done_d   = (state_d == S_DONE);

    if (accept) begin
      mode_d   = mode_e'(mode);
      fill_d   = fill_value;
      stride_d = stride;
      k_d      = '0;
      wren_d   = 1'b1;
      unique case (mode_e'(mode))
        M_IDENT:        data_d = '0;
        M_CONST, M_RAMP: data_d = fill_value;
        default:        data_d = REV_TOP;
      endcase
    end else if ((state_q == S_RUN) && !abort && !last) begin
      k_d    = k_q + ADDR_W'(1);
      wren_d = 1'b1;
      unique case (mode_q)
        M_IDENT: data_d = DATA_W'(k_d);
        M_CONST: data_d = fill_q;
        M_RAMP:  data_d = data_q + stride_q;
        default: data_d = REV_TOP - DATA_W'(k_d);
      endcase
    end
  end

  assign address = k_q;
  assign data    = data_q;
  assign wren    = wren_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_mem_fill_seq.sv
// Randomized scoreboard bench for mem_fill_seq at DEPTH 256, 16 and 1,
// all three instances sharing one stimulus stream.
module tb_mem_fill_seq;

  localparam int N_DUT = 3;

  logic clk;
  logic reset;
  logic start;
  logic abort;
  logic [1:0] mode;
  logic [7:0] fill_value;
  logic [7:0] stride;

  logic [N_DUT-1:0][7:0] addr_o;
  logic [N_DUT-1:0][7:0] data_o;
  logic [N_DUT-1:0]      wren_o;
  logic [N_DUT-1:0]      busy_o;
  logic [N_DUT-1:0]      done_o;

  int n_checks = 0;
  int n_fail   = 0;

  mem_fill_seq #(.ADDR_W(8), .DATA_W(8), .DEPTH(256)) dut0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .fill_value(fill_value), .stride(stride), .address(addr_o[0]),
    .data(data_o[0]), .wren(wren_o[0]), .busy(busy_o[0]), .done(done_o[0])
  );

  mem_fill_seq #(.ADDR_W(8), .DATA_W(8), .DEPTH(16)) dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .fill_value(fill_value), .stride(stride), .address(addr_o[1]),
    .data(data_o[1]), .wren(wren_o[1]), .busy(busy_o[1]), .done(done_o[1])
  );

  mem_fill_seq #(.ADDR_W(8), .DATA_W(8), .DEPTH(1)) dut2 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .fill_value(fill_value), .stride(stride), .address(addr_o[2]),
    .data(data_o[2]), .wren(wren_o[2]), .busy(busy_o[2]), .done(done_o[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: fill behaviour stated as plain arithmetic on the index.
  localparam int ST_IDLE = 0;
  localparam int ST_RUN  = 1;
  localparam int ST_DONE = 2;

  typedef logic [15:0] wr_q_t [$];
  wr_q_t exp_q [N_DUT];

  int m_state [N_DUT] = '{default: 0};
  int m_k     [N_DUT] = '{default: 0};
  int m_mode  [N_DUT] = '{default: 0};
  int m_fv    [N_DUT] = '{default: 0};
  int m_st    [N_DUT] = '{default: 0};
  int m_addr  [N_DUT] = '{default: 0};
  int m_data  [N_DUT] = '{default: 0};

  function automatic int depth_of(input int i);
    case (i)
      0:       return 256;
      1:       return 16;
      default: return 1;
    endcase
  endfunction

  function automatic int pattern(input int md, input int fv, input int st, input int k, input int depth);
    case (md)
      0:       return k & 255;
      1:       return fv;
      2:       return (fv + k * st) & 255;
      default: return (depth - 1 - k) & 255;
    endcase
  endfunction

  task automatic issue(input int i);
    m_addr[i] = m_k[i];
    m_data[i] = pattern(m_mode[i], m_fv[i], m_st[i], m_k[i], depth_of(i));
    exp_q[i].push_back({m_addr[i][7:0], m_data[i][7:0]});
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    for (int i = 0; i < N_DUT; i++) begin
      if (reset) begin
        m_state[i] = ST_IDLE;
        m_k[i] = 0; m_mode[i] = 0; m_fv[i] = 0; m_st[i] = 0;
        m_addr[i] = 0; m_data[i] = 0;
        exp_q[i].delete();
      end else if (abort) begin
        m_state[i] = ST_IDLE;
      end else if (m_state[i] == ST_RUN) begin
        if (m_k[i] == depth_of(i) - 1) begin
          m_state[i] = ST_DONE;
        end else begin
          m_k[i]++;
          issue(i);
        end
      end else if (start) begin
        m_mode[i] = int'(mode);
        m_fv[i] = int'(fill_value);
        m_st[i] = int'(stride);
        m_k[i] = 0;
        m_state[i] = ST_RUN;
        issue(i);
      end
    end
  end

  // Monitor: pops one expected write per presented write, checks status.
  initial forever begin
    logic [15:0] e;
    @(negedge clk);
    for (int i = 0; i < N_DUT; i++) begin
      check($sformatf("sb_pending_vs_wren[%0d]", i), exp_q[i].size(), {31'b0, wren_o[i]});
      if (wren_o[i] && exp_q[i].size() > 0) begin
        e = exp_q[i].pop_front();
        check($sformatf("wr_addr[%0d]", i), addr_o[i], e[15:8]);
        check($sformatf("wr_data[%0d]", i), data_o[i], e[7:0]);
      end else if (!wren_o[i]) begin
        check($sformatf("hold_addr[%0d]", i), addr_o[i], m_addr[i]);
        check($sformatf("hold_data[%0d]", i), data_o[i], m_data[i]);
      end
      check($sformatf("busy[%0d]", i), busy_o[i], m_state[i] == ST_RUN);
      check($sformatf("done[%0d]", i), done_o[i], m_state[i] == ST_DONE);
    end
  end

  task automatic drive(input logic st, input logic ab, input int md, input int fv, input int sd);
    @(negedge clk);
    start = st;
    abort = ab;
    mode = md[1:0];
    fill_value = fv[7:0];
    stride = sd[7:0];
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255));
  endtask

  task automatic wait_done(input int budget);
    for (int c = 0; c < budget && !done_o[0]; c++) drive_idle();
    check("done_reached", done_o[0], 1);
  endtask

  task automatic wait_addr(input int target, input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (wren_o[0] && addr_o[0] == target[7:0]) break;
    end
    check("reach_addr", addr_o[0], target);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < N_DUT; i++) begin
      check($sformatf("%s_addr[%0d]", tag, i), addr_o[i], 0);
      check($sformatf("%s_data[%0d]", tag, i), data_o[i], 0);
      check($sformatf("%s_wren[%0d]", tag, i), wren_o[i], 0);
      check($sformatf("%s_busy[%0d]", tag, i), busy_o[i], 0);
      check($sformatf("%s_done[%0d]", tag, i), done_o[i], 0);
    end
  endtask

  initial begin
    start = 1'b0; abort = 1'b0; mode = 2'd0; fill_value = 8'h00; stride = 8'h00;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1 check_reset_outputs("rst_init");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    drive_idle();

    // Identity fill.
    drive(1'b1, 1'b0, 0, $urandom_range(0, 255), $urandom_range(0, 255));
    wait_done(300);
    check("idle_busy_after_fill", busy_o[0], 0);

    // Ramp with wrap: F0, F3, ..., FF, 02, ...
    drive(1'b1, 1'b0, 2, 'hF0, 'h03);
    wait_done(300);

    // Reverse identity, then constant A5.
    drive(1'b1, 1'b0, 3, $urandom_range(0, 255), $urandom_range(0, 255));
    wait_done(300);
    drive(1'b1, 1'b0, 1, 'hA5, $urandom_range(0, 255));
    wait_done(300);

    // Abort right after the write at address 10.
    drive(1'b1, 1'b0, 0, 0, 0);
    drive_idle();
    wait_addr(10, 50);
    abort = 1'b1;
    drive_idle();
    check("abort_wren", wren_o[0], 0);
    check("abort_busy", busy_o[0], 0);
    check("abort_done", done_o[0], 0);
    drive(1'b1, 1'b0, 0, 0, 0);
    drive_idle();
    check("restart_addr0", addr_o[0], 0);
    wait_done(300);

    // Ramp with start toggling and configuration churn during the fill.
    drive(1'b1, 1'b0, 2, $urandom_range(0, 255), $urandom_range(0, 255));
    repeat (60) drive($urandom_range(0, 1), 1'b0, $urandom_range(0, 3),
                      $urandom_range(0, 255), $urandom_range(0, 255));
    for (int c = 0; c < 400; c++) begin
      drive(1'b1, 1'b0, $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255));
      if (done_o[0]) break;
    end
    check("done_with_start_held", done_o[0], 1);
    drive(1'b1, 1'b0, $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255));
    check("held_start_done_drops", done_o[0], 0);
    check("held_start_busy", busy_o[0], 1);
    drive(1'b0, 1'b1, 0, 0, 0);
    drive_idle();

    // Reset pulse mid-fill, asserted and released between clock edges.
    drive(1'b1, 1'b0, $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255));
    drive_idle();
    wait_addr(100, 150);
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_mid");
    #4 reset = 1'b0;
    repeat (10) drive_idle();

    // Random traffic: sparse starts and aborts with random configuration.
    repeat (1500) drive($urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0,
                        $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255));
    repeat (5) drive_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_fill_seq.md
MEM_FILL_SEQ -- requirements
Module: mem_fill_seq

Interface
REQ-001 Parameter ADDR_W, default 8, address width in bits.
REQ-002 Parameter DATA_W, default 8, data width in bits.
REQ-003 Parameter DEPTH, default 256, number of words written per fill; 1 <= DEPTH <= 2^ADDR_W.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request a fill; sampled only in IDLE or DONE.
REQ-007 abort  input  1  terminate a fill in progress.
REQ-008 mode  input  2  fill pattern select: 0 identity, 1 constant, 2 ramp, 3 reverse identity.
REQ-009 fill_value  input  DATA_W  constant value (mode 1) or ramp base (mode 2).
REQ-010 stride  input  DATA_W  ramp increment (mode 2).
REQ-011 address  output  ADDR_W  write address to the memory port.
REQ-012 data  output  DATA_W  write data to the memory port.
REQ-013 wren  output  1  write enable; one word written per cycle while high.
REQ-014 busy  output  1  high while in RUN.
REQ-015 done  output  1  high while in DONE, i.e. after a completed, non-aborted fill.

Function
REQ-016 FSM states IDLE, RUN, DONE; all outputs registered.
REQ-017 IDLE/DONE with start=1 and abort=0 at an edge: latch mode, fill_value and stride, clear the write index k, enter RUN.
REQ-018 First write on the cycle after the start edge: wren=1, address=0, data=pattern(0).
REQ-019 In RUN, each cycle presents address=k and data=pattern(k) with wren=1, then increments k; exactly DEPTH consecutive wren cycles, addresses 0..DEPTH-1 ascending, no gaps.
REQ-020 pattern(k): mode 0 = k; mode 1 = fill_value; mode 2 = fill_value + k*stride; mode 3 = DEPTH-1-k.
REQ-021 All pattern arithmetic is modulo 2^DATA_W; k is zero-extended or truncated to DATA_W; the ramp is computed by an accumulator (add stride per write), with no multiplier.
REQ-022 The cycle after the write to DEPTH-1: wren=0, busy=0, done=1, state DONE; address and data hold their last values.
REQ-023 DONE holds done=1 until a new accepted start, which clears done on the same edge that enters RUN.
REQ-024 start in RUN is ignored; configuration inputs are not resampled during RUN.
REQ-025 abort=1 in RUN: on the next edge wren=0, busy=0, done=0, state IDLE; the write presented in the abort cycle completes and no further write occurs.
REQ-026 abort has priority over start in any state; abort in IDLE or DONE clears done and enters IDLE.
REQ-027 DEPTH=1: a single write cycle, then DONE.
REQ-028 Address never exceeds DEPTH-1; k wraps to 0 only via a new start.

Reset
REQ-029 Reset asserted: state IDLE, address=0, data=0, wren=0, busy=0, done=0, k=0, latched configuration=0, immediately and independent of clk.
REQ-030 Reset asserted mid-RUN aborts the fill without completing the current write; no write occurs until reset deasserts and a new start is accepted.

Verification
REQ-031 Defaults, mode 0, start pulse -> 256 wren cycles with address=data=0..255, then done=1, busy=0.
REQ-032 Mode 2, fill_value=8'hF0, stride=8'h03 -> data F0,F3,F6,...; writes 5 and 6 are 8'hFF and 8'h02 (wrap); 256 writes in total.
REQ-033 Mode 3, DEPTH=16 -> address 0..15 with data 15..0; mode 1, fill_value=8'hA5 -> all 256 writes carry 8'hA5.
REQ-034 Mode 0, abort after write at address 10 -> writes 0..10 only; next cycle wren=0, done=0, busy=0; a new start restarts at address 0.
REQ-035 Mode 2, start toggled in RUN and mode/stride changed mid-fill -> stream unaffected; start held high in DONE -> new fill begins, done drops.
REQ-036 Reset pulse mid-RUN at address 100, including between clock edges -> outputs at reset values immediately; no wren until the next start.
